dds_pulse_sequencer: RTL and testbench
======================================

Name: dds_pulse_sequencer

Overview:
Generates the DDS control strobes (io_update, osk, drctl) and the pulse_position window from the 16 trigger channels, and closes the loop on the DDS drover pin. Runs on clk_500m. The on-chip logic analyzer probes these same nets. One trigger starts one pulse: load the profile, ramp up, hold, ramp down, then return to idle.

Parameters:
NCH, 16, number of trigger channels.
IOUP_CYCLES, 4, io_update high width in clk_500m cycles (at least 1).
SETTLE_CYCLES, 8, wait from io_update fall to drctl rise (at least 1).
TIMEOUT, 4096, maximum cycles to wait for drover per ramp edge.
PW_W, 16, width of pulse_width.

Ports:
clk_500m  in  1  sole clock.
rst  in  1  asynchronous, active-high reset.
triger_pulse  in  NCH  trigger channels, synchronous to clk_500m, level.
chan_mask  in  NCH  1 = channel armed; quasi-static.
enable  in  1  0 = ignore new triggers; a sequence already running completes.
pulse_width  in  PW_W  HOLD length in cycles; 0 is treated as 1; sampled at trigger.
drover  in  1  DDS ramp-complete pin, asynchronous.
err_clr  in  1  single-cycle clear for the sticky flags.
io_update  out  1  DDS profile/register latch strobe.
drctl  out  1  DDS ramp direction (1 = up).
osk  out  1  DDS output shift key.
pulse_position  out  1  high while the output is at full amplitude (HOLD).
busy  out  1  high in every state except IDLE.
chan_id  out  4  index of the channel that started the current or last sequence.
missed  out  1  sticky; an armed edge arrived while busy.
timeout_err  out  1  sticky; drover wait exceeded TIMEOUT.

Behaviour:
- Reset: all outputs 0; FSM in IDLE; all counters 0; trigger history register 0; drover synchronizer 0.
- Edge detect: edge = triger_pulse & ~trig_d & chan_mask, where trig_d is the previous-cycle register.
- Start: when edge != 0, enable = 1 and the FSM is in IDLE, start a sequence. The lowest set index wins and goes to chan_id. pulse_width is latched at the same time.
- drover passes through a 2-flop synchronizer, giving drover_s. All drover decisions use a rising edge of drover_s.
- State IDLE: all strobes low. On start, go to UPDATE. io_update is high in the cycle after the trigger edge is sampled (1-cycle latency).
- State UPDATE: io_update = 1 for exactly IOUP_CYCLES cycles, then go to SETTLE.
- State SETTLE: all strobes low for SETTLE_CYCLES cycles, then go to RAMP_UP.
- State RAMP_UP: drctl = 1 and osk = 1. Wait for a drover_s rising edge, then go to HOLD.
- State HOLD: drctl = 1, osk = 1, pulse_position = 1 for exactly max(pulse_width, 1) cycles, then go to RAMP_DN.
- State RAMP_DN: drctl = 0 and osk = 1. Wait for a drover_s rising edge, then go to IDLE with osk = 0.
- Timeout: the wait counter clears on entry to RAMP_UP and to RAMP_DN. If it reaches TIMEOUT, set timeout_err, force all strobes low and go to IDLE. The HOLD phase is skipped in this case.
- missed: set when edge & chan_mask is non-zero while busy = 1. This includes the last cycle of RAMP_DN.
- A trigger in the same cycle the FSM returns to IDLE is missed. It does not start a sequence.
- Sticky flags: err_clr clears missed and timeout_err. If a set condition occurs in the same cycle as err_clr, set wins.
- enable falling mid-sequence: no effect on the sequence in progress.
- enable = 0 in IDLE: edges are ignored and do not set missed.
- Simultaneous edges on several channels: one sequence starts; the lowest index wins; missed is not set.
- Reset asserted mid-sequence: all outputs go to 0 immediately (asynchronous). After reset release, the FSM is in IDLE.
- Counters are sized to hold the largest of IOUP_CYCLES, SETTLE_CYCLES, TIMEOUT and 2^PW_W. None of them wraps.

Decomposition:
- Shared package dds_ctrl_pkg holds:
  - state enum: IDLE, UPDATE, SETTLE, RAMP_UP, HOLD, RAMP_DN;
  - default timing constants;
  - a function clog2.
- One sub-module, dds_trig_arbiter: edge detect plus lowest-index priority encoder. Outputs a valid flag and a 4-bit index.
- The drover synchronizer is inline.

Test Plan:
- Basic pulse: mask = 0x0001, pulse_width = 10, trigger ch0 rising. Expect:
  - io_update high for 4 cycles, starting 1 cycle after the edge;
  - 8 idle cycles;
  - drctl and osk rise;
  - drover pulse → pulse_position high for exactly 10 cycles;
  - drctl falls;
  - drover → osk falls, busy = 0, chan_id = 0.
- Priority: ch5 and ch9 rise in the same cycle with mask 0xFFFF → chan_id = 5, one sequence, missed = 0.
- Masking and busy: mask = 0x0100, trigger ch3 → no activity. Then trigger ch8, and pulse ch8 again during HOLD → the first sequence completes unchanged and missed = 1. Then err_clr → missed = 0.
- Timeout: TIMEOUT = 64, drover never toggles → timeout_err = 1 at 64 cycles into RAMP_UP, all strobes 0, busy = 0. pulse_position never goes high.
- Reset mid-HOLD: assert rst asynchronously (between clock edges) → all outputs 0 before the next clock edge. After release, a new ch0 trigger produces a normal sequence.
- pulse_width = 0 and enable = 0: with pulse_width = 0, pulse_position is high for exactly 1 cycle. With enable = 0 in IDLE, triggers produce no activity and missed stays 0.

Source files
------------

// File: rtl/dds_ctrl_pkg.sv
// Shared types and timing defaults for the DDS pulse sequencer.
// Holds the sequencer state encoding and small elaboration-time helpers.
package dds_ctrl_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StUpdate,
    StSettle,
    StRampUp,
    StHold,
    StRampDn
  } state_e;

  localparam int unsigned DefNch          = 16;
  localparam int unsigned DefIoupCycles   = 4;
  localparam int unsigned DefSettleCycles = 8;
  localparam int unsigned DefTimeout      = 4096;
  localparam int unsigned DefPwW          = 16;
  localparam int unsigned ChanIdW         = 4;

  // Ceiling log2, never below 1 so it can size a vector directly.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned res;
    int unsigned v;
    res = 0;
    v   = (value > 0) ? value - 1 : 0;
    while (v > 0) begin
      res++;
      v = v >> 1;
    end
    return (res == 0) ? 1 : res;
  endfunction

  function automatic int unsigned max2(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/dds_trig_arbiter.sv
// Trigger edge detector with lowest-index-wins priority encoding.
// valid_o flags any armed rising edge this cycle; idx_o names the winner.
module dds_trig_arbiter
  import dds_ctrl_pkg::*;
#(
  parameter int unsigned NCH = DefNch
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [NCH-1:0]     trig_i,
  input  logic [NCH-1:0]     mask_i,
  output logic               valid_o,
  output logic [ChanIdW-1:0] idx_o
);

  logic [NCH-1:0] trig_q;
  logic [NCH-1:0] edges;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      trig_q <= '0;
    end else begin
      trig_q <= trig_i;
    end
  end

  assign edges   = trig_i & ~trig_q & mask_i;
  assign valid_o = |edges;

  // Scan from the top so the lowest set index is the last assignment.
  always_comb begin
    idx_o = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (edges[i]) begin
        idx_o = ChanIdW'(i);
      end
    end
  end

endmodule

// File: rtl/dds_pulse_sequencer.sv
// DDS pulse sequencer: turns an armed trigger edge into io_update / ramp-up /
// hold / ramp-down strobes, closing each ramp on the synchronised drover pin.
module dds_pulse_sequencer
  import dds_ctrl_pkg::*;
#(
  parameter int unsigned NCH           = DefNch,
  parameter int unsigned IOUP_CYCLES   = DefIoupCycles,
  parameter int unsigned SETTLE_CYCLES = DefSettleCycles,
  parameter int unsigned TIMEOUT       = DefTimeout,
  parameter int unsigned PW_W          = DefPwW
) (
  input  logic               clk_500m,
  input  logic               rst,
  input  logic [NCH-1:0]     triger_pulse,
  input  logic [NCH-1:0]     chan_mask,
  input  logic               enable,
  input  logic [PW_W-1:0]    pulse_width,
  input  logic               drover,
  input  logic               err_clr,
  output logic               io_update,
  output logic               drctl,
  output logic               osk,
  output logic               pulse_position,
  output logic               busy,
  output logic [ChanIdW-1:0] chan_id,
  output logic               missed,
  output logic               timeout_err
);

  localparam int unsigned CntMax =
      max2(max2(IOUP_CYCLES, SETTLE_CYCLES), max2(TIMEOUT, 32'd1 << PW_W));
  localparam int unsigned CntW = clog2(CntMax + 1);

  localparam logic [CntW-1:0] IoupLast    = CntW'(IOUP_CYCLES - 1);
  localparam logic [CntW-1:0] SettleLast  = CntW'(SETTLE_CYCLES - 1);
  localparam logic [CntW-1:0] TimeoutLast = CntW'(TIMEOUT - 1);

  state_e              state_q, state_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [PW_W-1:0]     pw_q;
  logic [PW_W-1:0]     pw_eff;
  logic [CntW-1:0]     hold_last;
  logic [ChanIdW-1:0]  chan_id_q;
  logic                missed_q, missed_d;
  logic                timeout_q, timeout_d;
  logic                timeout_hit;
  logic                trig_valid;
  logic [ChanIdW-1:0]  trig_idx;
  logic                start;
  logic                drover_meta_q, drover_s_q, drover_prev_q;
  logic                drover_rise;

  dds_trig_arbiter #(
    .NCH (NCH)
  ) u_arbiter (
    .clk_i   (clk_500m),
    .rst_i   (rst),
    .trig_i  (triger_pulse),
    .mask_i  (chan_mask),
    .valid_o (trig_valid),
    .idx_o   (trig_idx)
  );

  assign start = trig_valid & enable & (state_q == StIdle);

  // drover is asynchronous to clk_500m; the third flop only provides edge history.
  always_ff @(posedge clk_500m or posedge rst) begin
    if (rst) begin
      drover_meta_q <= 1'b0;
      drover_s_q    <= 1'b0;
      drover_prev_q <= 1'b0;
    end else begin
      drover_meta_q <= drover;
      drover_s_q    <= drover_meta_q;
      drover_prev_q <= drover_s_q;
    end
  end

  assign drover_rise = drover_s_q & ~drover_prev_q;

  // A zero pulse width still holds for one cycle.
  assign pw_eff    = (pw_q == '0) ? PW_W'(1) : pw_q;
  assign hold_last = CntW'(pw_eff) - CntW'(1);

  always_ff @(posedge clk_500m or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    timeout_hit = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StUpdate;
          cnt_d   = '0;
        end
      end
      StUpdate: begin
        if (cnt_q == IoupLast) begin
          state_d = StSettle;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StSettle: begin
        if (cnt_q == SettleLast) begin
          state_d = StRampUp;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StRampUp: begin
        if (drover_rise) begin
          state_d = StHold;
          cnt_d   = '0;
        end else if (cnt_q == TimeoutLast) begin
          state_d     = StIdle;
          cnt_d       = '0;
          timeout_hit = 1'b1;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StHold: begin
        if (cnt_q == hold_last) begin
          state_d = StRampDn;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StRampDn: begin
        if (drover_rise) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else if (cnt_q == TimeoutLast) begin
          state_d     = StIdle;
          cnt_d       = '0;
          timeout_hit = 1'b1;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  // Strobes decode straight from the state register so reset clears them at once.
  always_comb begin
    io_update      = 1'b0;
    drctl          = 1'b0;
    osk            = 1'b0;
    pulse_position = 1'b0;
    busy           = (state_q != StIdle);
    unique case (state_q)
      StUpdate: io_update = 1'b1;
      StRampUp: begin
        drctl = 1'b1;
        osk   = 1'b1;
      end
      StHold: begin
        drctl          = 1'b1;
        osk            = 1'b1;
        pulse_position = 1'b1;
      end
      StRampDn: osk = 1'b1;
      default: ;
    endcase
  end

  // Set wins over a simultaneous clear.
  assign missed_d  = (trig_valid & busy) | (missed_q & ~err_clr);
  assign timeout_d = timeout_hit | (timeout_q & ~err_clr);

  always_ff @(posedge clk_500m or posedge rst) begin
    if (rst) begin
      cnt_q     <= '0;
      pw_q      <= '0;
      chan_id_q <= '0;
      missed_q  <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      missed_q  <= missed_d;
      timeout_q <= timeout_d;
      if (start) begin
        pw_q      <= pulse_width;
        chan_id_q <= trig_idx;
      end
    end
  end

  assign chan_id     = chan_id_q;
  assign missed      = missed_q;
  assign timeout_err = timeout_q;

  hold_implies_ramp_up : assert property (
    @(posedge clk_500m) disable iff (rst) pulse_position |-> (osk && drctl));
  update_excludes_osk : assert property (
    @(posedge clk_500m) disable iff (rst) !(io_update && osk));

endmodule

// File: tb/tb_dds_pulse_sequencer.sv
// Scoreboard bench for dds_pulse_sequencer: stimulus queues the expected strobe
// segments, a negedge monitor compares each segment's value and length.
`timescale 1ns/1ps
module tb_dds_pulse_sequencer;
  import dds_ctrl_pkg::*;

  localparam int unsigned Nch = 16;
  localparam int unsigned PwW = 16;

  // Strobe vector {io_update, drctl, osk, pulse_position, busy}.
  localparam logic [4:0] VIdle = 5'b00000;
  localparam logic [4:0] VUpd  = 5'b10001;
  localparam logic [4:0] VSet  = 5'b00001;
  localparam logic [4:0] VUp   = 5'b01101;
  localparam logic [4:0] VHold = 5'b01111;
  localparam logic [4:0] VDn   = 5'b00101;

  logic               clk_500m = 1'b0;
  logic               rst;
  logic [Nch-1:0]     triger_pulse;
  logic [Nch-1:0]     chan_mask;
  logic               enable;
  logic [PwW-1:0]     pulse_width;
  logic               drover;
  logic               err_clr;
  logic               io_update, drctl, osk, pulse_position, busy;
  logic [ChanIdW-1:0] chan_id;
  logic               missed, timeout_err;

  always #1 clk_500m = ~clk_500m;

  dds_pulse_sequencer #(
    .NCH           (Nch),
    .IOUP_CYCLES   (4),
    .SETTLE_CYCLES (8),
    .TIMEOUT       (64),
    .PW_W          (PwW)
  ) dut (
    .clk_500m       (clk_500m),
    .rst            (rst),
    .triger_pulse   (triger_pulse),
    .chan_mask      (chan_mask),
    .enable         (enable),
    .pulse_width    (pulse_width),
    .drover         (drover),
    .err_clr        (err_clr),
    .io_update      (io_update),
    .drctl          (drctl),
    .osk            (osk),
    .pulse_position (pulse_position),
    .busy           (busy),
    .chan_id        (chan_id),
    .missed         (missed),
    .timeout_err    (timeout_err)
  );

  typedef struct {
    logic [4:0] vec;
    int         len;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   fails  = 0;

  function automatic logic [4:0] vec_now();
    return {io_update, drctl, osk, pulse_position, busy};
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s got 0x%0h want 0x%0h at %0t", name, got, want, $time);
    end
  endtask

  task automatic push(input logic [4:0] vec, input int len);
    exp_t e;
    e.vec = vec;
    e.len = len;
    exp_q.push_back(e);
  endtask

  // Full sequence; -1 marks segments whose length depends on drover timing.
  task automatic push_seq(input int pw);
    push(VUpd, 4);
    push(VSet, 8);
    push(VUp, -1);
    push(VHold, (pw == 0) ? 1 : pw);
    push(VDn, -1);
    push(VIdle, -1);
  endtask

  // Monitor: every change of the strobe vector closes one segment and opens the next.
  logic [4:0] prev_vec = VIdle;
  int         run_len  = 0;
  int         cur_len  = -1;

  always @(negedge clk_500m) begin
    logic [4:0] v;
    exp_t       e;
    v = vec_now();
    if (v !== prev_vec) begin
      if (cur_len >= 0) begin
        checks++;
        if (run_len != cur_len) begin
          fails++;
          $display("FAIL seg_len vec %b got %0d cycles want %0d at %0t",
                   prev_vec, run_len, cur_len, $time);
        end
      end
      checks++;
      if (exp_q.size() == 0) begin
        fails++;
        cur_len = -1;
        $display("FAIL seg_unexpected got %b want no activity at %0t", v, $time);
      end else begin
        e = exp_q.pop_front();
        cur_len = e.len;
        if (e.vec !== v) begin
          fails++;
          $display("FAIL seg_vec got %b want %b at %0t", v, e.vec, $time);
        end
      end
      run_len  = 1;
      prev_vec = v;
    end else begin
      run_len++;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk_500m);
  endtask

  task automatic wait_vec(input logic [4:0] v, input int limit, input string name);
    int k = 0;
    while (vec_now() !== v && k < limit) begin
      tick(1);
      k++;
    end
    check(name, vec_now(), v);
  endtask

  task automatic start_trig(input logic [Nch-1:0] pattern);
    triger_pulse = pattern;
    tick(1);
    check("start_latency", io_update, 1);
    triger_pulse = '0;
  endtask

  task automatic drover_pulse();
    drover = 1'b1;
    tick(3);
    drover = 1'b0;
    tick(2);
  endtask

  task automatic run_normal(input logic [Nch-1:0] pattern);
    start_trig(pattern);
    wait_vec(VUp, 40, "wait_ramp_up");
    drover_pulse();
    wait_vec(VDn, 200, "wait_ramp_dn");
    drover_pulse();
    wait_vec(VIdle, 40, "wait_idle");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got no finish want finish by %0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst          = 1'b1;
    triger_pulse = '0;
    chan_mask    = '0;
    enable       = 1'b1;
    pulse_width  = '0;
    drover       = 1'b0;
    err_clr      = 1'b0;
    tick(2);
    check("reset_strobes", vec_now(), VIdle);
    check("reset_chan_id", chan_id, 0);
    check("reset_missed", missed, 0);
    check("reset_timeout", timeout_err, 0);
    rst = 1'b0;
    tick(2);

    // Basic pulse on ch0.
    chan_mask   = 16'h0001;
    pulse_width = 16'd10;
    push_seq(10);
    run_normal(16'h0001);
    check("basic_chan_id", chan_id, 0);
    check("basic_missed", missed, 0);
    tick(3);

    // Simultaneous edges: lowest index wins, no miss.
    chan_mask   = 16'hFFFF;
    pulse_width = 16'd3;
    push_seq(3);
    run_normal(16'h0220);
    check("prio_chan_id", chan_id, 5);
    check("prio_missed", missed, 0);
    tick(3);

    // Masked channel does nothing; retrigger during HOLD is missed.
    chan_mask    = 16'h0100;
    triger_pulse = 16'h0008;
    tick(20);
    triger_pulse = '0;
    check("masked_busy", busy, 0);
    pulse_width = 16'd10;
    push_seq(10);
    start_trig(16'h0100);
    pulse_width = 16'd99;
    wait_vec(VUp, 40, "miss_wait_ramp_up");
    drover_pulse();
    wait_vec(VHold, 20, "miss_wait_hold");
    triger_pulse = 16'h0100;
    tick(1);
    triger_pulse = '0;
    wait_vec(VDn, 40, "miss_wait_ramp_dn");
    drover_pulse();
    wait_vec(VIdle, 40, "miss_wait_idle");
    check("miss_chan_id", chan_id, 8);
    check("miss_set", missed, 1);
    err_clr = 1'b1;
    tick(1);
    err_clr = 1'b0;
    check("miss_cleared", missed, 0);
    tick(3);

    // drover never arrives: abort after 64 cycles of RAMP_UP, no HOLD.
    chan_mask   = 16'h0001;
    pulse_width = 16'd5;
    push(VUpd, 4);
    push(VSet, 8);
    push(VUp, 64);
    push(VIdle, -1);
    start_trig(16'h0001);
    wait_vec(VIdle, 200, "tmo_wait_idle");
    check("tmo_flag", timeout_err, 1);
    check("tmo_busy", busy, 0);
    check("tmo_missed", missed, 0);
    err_clr = 1'b1;
    tick(1);
    err_clr = 1'b0;
    check("tmo_cleared", timeout_err, 0);
    tick(3);

    // Asynchronous reset in the middle of HOLD.
    chan_mask   = 16'hFFFF;
    pulse_width = 16'd20;
    push(VUpd, 4);
    push(VSet, 8);
    push(VUp, -1);
    push(VHold, -1);
    push(VIdle, -1);
    start_trig(16'h0010);
    wait_vec(VUp, 40, "rst_wait_ramp_up");
    drover_pulse();
    check("rst_in_hold", vec_now(), VHold);
    check("rst_pre_chan_id", chan_id, 4);
    @(posedge clk_500m);
    #0.5;
    rst = 1'b1;
    #0.2;
    check("rst_async_strobes", vec_now(), VIdle);
    check("rst_async_chan_id", chan_id, 0);
    tick(3);
    rst = 1'b0;
    tick(2);
    pulse_width = 16'd2;
    push_seq(2);
    run_normal(16'h0001);
    check("post_rst_chan_id", chan_id, 0);
    tick(3);

    // Zero pulse width holds for one cycle.
    chan_mask   = 16'h0001;
    pulse_width = 16'd0;
    push_seq(0);
    run_normal(16'h0001);
    tick(3);

    // Disabled in IDLE: edges ignored, no miss.
    enable       = 1'b0;
    triger_pulse = 16'h0001;
    tick(1);
    triger_pulse = '0;
    tick(20);
    check("disabled_busy", busy, 0);
    check("disabled_missed", missed, 0);
    enable = 1'b1;

    tick(5);
    check("scoreboard_drain", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
